// File: rtl/sound_mixer.sv
// Audio mixer: snapshots background + 9 sfx channels on a strobe, mixes them one
// multiply-accumulate per cycle, saturates to an 8-bit sample and drives a PWM pin.
module sound_mixer #(
  parameter int MIX_SHIFT    = 3,
  parameter int PWM_PRESCALE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mute,
  input  logic [7:0] bground,
  input  logic [3:0] bamp,
  input  logic [7:0] sfx0,
  input  logic [7:0] sfx1,
  input  logic [7:0] sfx2,
  input  logic [7:0] sfx3,
  input  logic [7:0] sfx4,
  input  logic [7:0] sfx5,
  input  logic [7:0] sfx6,
  input  logic [7:0] sfx7,
  input  logic [7:0] sfx8,
  input  logic [3:0] sfx_amp0,
  input  logic [3:0] sfx_amp1,
  input  logic [3:0] sfx_amp2,
  input  logic [3:0] sfx_amp3,
  input  logic [3:0] sfx_amp4,
  input  logic [3:0] sfx_amp5,
  input  logic [3:0] sfx_amp6,
  input  logic [3:0] sfx_amp7,
  input  logic [3:0] sfx_amp8,
  output logic [7:0] mix_out,
  output logic       mix_valid,
  output logic       busy,
  output logic       overrun,
  output logic       pwm_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;

  localparam logic [PWM_PRESCALE:0] PS_MAX = (PWM_PRESCALE + 1)'((1 << PWM_PRESCALE) - 1);

  state_t                  state;
  logic [9:0][7:0]         smp;
  logic [9:0][3:0]         amp;
  logic [3:0]              ch;
  logic signed [15:0]      acc;
  logic [7:0]              sel_smp;
  logic [3:0]              sel_amp;
  logic signed [7:0]       diff;
  logic signed [15:0]      term;
  logic signed [15:0]      shifted;
  logic [7:0]              result;
  logic [PWM_PRESCALE:0]   pre;
  logic                    tick;
  logic [7:0]              pwm_cnt;
  logic [7:0]              level;

  // Channel select and signed MAC term; sample-128 is just the MSB inverted.
  always_comb begin
    sel_smp = 8'h80;
    sel_amp = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (ch == 4'(i)) begin
        sel_smp = smp[i];
        sel_amp = amp[i];
      end else begin
        sel_smp = sel_smp;
        sel_amp = sel_amp;
      end
    end
    diff = signed'({~sel_smp[7], sel_smp[6:0]});
    term = signed'({{8{diff[7]}}, diff} * {12'd0, sel_amp});
  end

  // Scale and saturate the finished sum back into offset-binary.
  always_comb begin
    shifted = acc >>> MIX_SHIFT;
    if (shifted > 16'sd127) begin
      result = 8'hFF;
    end else if (shifted < -16'sd128) begin
      result = 8'h00;
    end else begin
      result = {~shifted[7], shifted[6:0]};
    end
  end

  // Mix sequencer: capture, ten MAC cycles, then publish.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      smp       <= '0;
      amp       <= '0;
      ch        <= 4'd0;
      acc       <= 16'sd0;
      mix_out   <= 8'h80;
      mix_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            smp   <= {sfx8, sfx7, sfx6, sfx5, sfx4, sfx3, sfx2, sfx1, sfx0, bground};
            amp   <= {sfx_amp8, sfx_amp7, sfx_amp6, sfx_amp5, sfx_amp4,
                      sfx_amp3, sfx_amp2, sfx_amp1, sfx_amp0, bamp};
            acc   <= 16'sd0;
            ch    <= 4'd0;
            busy  <= 1'b1;
            state <= ACC;
          end else begin
            state <= IDLE;
          end
        end
        ACC: begin
          if (en) overrun <= 1'b1;
          acc <= acc + term;
          ch  <= ch + 4'd1;
          if (ch == 4'd9) state <= DONE;
          else            state <= ACC;
        end
        DONE: begin
          if (en) overrun <= 1'b1;
          mix_out   <= mute ? 8'h80 : result;
          mix_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign tick = (pre == PS_MAX);

  // PWM generator; the level is only reloaded at the period boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre     <= '0;
      pwm_cnt <= 8'd0;
      level   <= 8'h80;
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= (pwm_cnt < level);
      if (tick) begin
        pre     <= '0;
        pwm_cnt <= pwm_cnt + 8'd1;
        if (pwm_cnt == 8'd255) level <= mix_out;
        else                   level <= level;
      end else begin
        pre     <= pre + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sound_mixer.sv
// Self-checking bench for sound_mixer: table vectors, random mixes against an
// arithmetic reference model, and hand sequences for overrun, reset and PWM.
module tb_sound_mixer;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            mute;
  logic [9:0][7:0] smp_in;
  logic [9:0][3:0] amp_in;
  logic [7:0]      mix_out;
  logic            mix_valid;
  logic            busy;
  logic            overrun;
  logic            pwm_out;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [9:0][7:0] smp;
    logic [9:0][3:0] amp;
    logic            mute;
    logic [7:0]      exp;
  } vec_t;

  vec_t tbl [5];

  sound_mixer #(.MIX_SHIFT(3), .PWM_PRESCALE(0)) dut (
    .clk(clk), .rst(rst), .en(en), .mute(mute),
    .bground(smp_in[0]), .bamp(amp_in[0]),
    .sfx0(smp_in[1]), .sfx1(smp_in[2]), .sfx2(smp_in[3]), .sfx3(smp_in[4]),
    .sfx4(smp_in[5]), .sfx5(smp_in[6]), .sfx6(smp_in[7]), .sfx7(smp_in[8]),
    .sfx8(smp_in[9]),
    .sfx_amp0(amp_in[1]), .sfx_amp1(amp_in[2]), .sfx_amp2(amp_in[3]),
    .sfx_amp3(amp_in[4]), .sfx_amp4(amp_in[5]), .sfx_amp5(amp_in[6]),
    .sfx_amp6(amp_in[7]), .sfx_amp7(amp_in[8]), .sfx_amp8(amp_in[9]),
    .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy),
    .overrun(overrun), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] bg, input logic [3:0] ba,
                              input logic [7:0] sv, input logic [3:0] sa,
                              input logic mt, input logic [7:0] ex);
    vec_t v;
    v.smp  = {{9{sv}}, bg};
    v.amp  = {{9{sa}}, ba};
    v.mute = mt;
    v.exp  = ex;
    return v;
  endfunction

  // Reference: weighted sum of signed samples, floor-divide by 8, clamp, re-offset.
  function automatic logic [7:0] model(input vec_t v);
    int s;
    s = 0;
    for (int i = 0; i < 10; i++) s += (int'(v.smp[i]) - 128) * int'(v.amp[i]);
    s = s >>> 3;
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    if (v.mute) return 8'h80;
    return 8'(s + 128);
  endfunction

  task automatic do_mix(input vec_t v, input string name);
    int         lat;
    int         bc;
    logic [7:0] got;
    lat = 0;
    bc  = 0;
    got = 8'h00;
    @(negedge clk);
    smp_in = v.smp;
    amp_in = v.amp;
    mute   = v.mute;
    en     = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      smp_in[i] = 8'($urandom);
      amp_in[i] = 4'($urandom);
    end
    for (int k = 1; k <= 20; k++) begin
      bc += int'(busy);
      @(posedge clk);
      #1;
      if (mix_valid) begin
        lat = k;
        got = mix_out;
        break;
      end
    end
    chk({name, " latency"}, lat, 11);
    chk({name, " busy_cycles"}, bc, 11);
    chk({name, " mix_out"}, got, v.exp);
    chk({name, " busy_after"}, busy, 0);
    @(posedge clk);
    #1;
    chk({name, " valid_one_cycle"}, mix_valid, 0);
  endtask

  task automatic count_hi(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      hi += int'(pwm_out);
    end
  endtask

  initial begin
    int   hi;
    int   h1;
    int   h2;
    int   vcnt;
    int   pos0;
    int   pos1;
    logic prev;
    logic found;
    vec_t rv;

    tbl[0] = mk(8'hA0, 4'd4,  8'h80, 4'd15, 1'b0, 8'h90);
    tbl[1] = mk(8'h00, 4'd15, 8'h00, 4'd15, 1'b0, 8'h00);
    tbl[2] = mk(8'hFF, 4'd15, 8'hFF, 4'd15, 1'b0, 8'hFF);
    tbl[3] = mk(8'hA0, 4'd4,  8'h80, 4'd15, 1'b1, 8'h80);
    tbl[4] = mk(8'h00, 4'd4,  8'h80, 4'd0,  1'b0, 8'h40);

    rst    = 1'b0;
    en     = 1'b0;
    mute   = 1'b0;
    smp_in = '0;
    amp_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset mix_out", mix_out, 8'h80);
    chk("reset mix_valid", mix_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset overrun", overrun, 0);
    chk("reset pwm_out", pwm_out, 0);
    @(negedge clk);
    rst = 1'b1;
    count_hi(256, hi);
    chk("pwm idle duty", hi, 128);
    chk("idle mix_valid", mix_valid, 0);

    for (int t = 0; t < 5; t++) do_mix(tbl[t], $sformatf("vec%0d", t));

    count_hi(260, hi);
    count_hi(256, hi);
    chk("pwm duty 0x40", hi, 64);

    // Lock onto a period start, then change mix_out mid-period.
    found = 1'b0;
    prev  = pwm_out;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (pwm_out && !prev) begin
        found = 1'b1;
        break;
      end
      prev = pwm_out;
    end
    chk("pwm period sync", found, 1);
    h1 = 0;
    h2 = 0;
    fork
      begin
        h1 = int'(pwm_out);
        for (int i = 1; i < 256; i++) begin
          @(posedge clk);
          #1;
          h1 += int'(pwm_out);
        end
        count_hi(256, h2);
      end
      begin
        repeat (100) @(posedge clk);
        do_mix(tbl[0], "midperiod");
      end
    join
    chk("pwm old period keeps duty", h1, 64);
    chk("pwm next period new duty", h2, 144);

    chk("overrun clear before", overrun, 0);
    vcnt = 0;
    pos0 = -1;
    pos1 = -1;
    @(negedge clk);
    smp_in = tbl[0].smp;
    amp_in = tbl[0].amp;
    mute   = 1'b0;
    for (int c = 0; c < 27; c++) begin
      if (c > 0) @(negedge clk);
      en = (c == 0 || c == 5 || c == 12);
      @(posedge clk);
      #1;
      if (mix_valid) begin
        if (vcnt == 0) pos0 = c;
        else           pos1 = c;
        vcnt++;
      end
      if (c == 6) chk("overrun set", overrun, 1);
    end
    en = 1'b0;
    chk("overrun valid count", vcnt, 2);
    chk("overrun first valid edge", pos0, 11);
    chk("overrun third en valid edge", pos1, 23);
    chk("overrun mix_out", mix_out, 8'h90);

    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 10; i++) begin
        rv.smp[i] = 8'($urandom);
        rv.amp[i] = 4'($urandom);
      end
      rv.mute = ($urandom_range(0, 3) == 0);
      rv.exp  = model(rv);
      do_mix(rv, $sformatf("rand%0d", r));
    end
    chk("overrun sticky", overrun, 1);

    do_mix(tbl[0], "pre_reset");
    @(negedge clk);
    smp_in = tbl[2].smp;
    amp_in = tbl[2].amp;
    en     = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midacc reset mix_out", mix_out, 8'h80);
    chk("midacc reset busy", busy, 0);
    chk("midacc reset overrun", overrun, 0);
    chk("midacc reset pwm_out", pwm_out, 0);
    @(negedge clk);
    rst  = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      vcnt += int'(mix_valid);
    end
    chk("midacc no mix_valid", vcnt, 0);
    chk("midacc busy idle", busy, 0);
    chk("midacc mix_out held", mix_out, 8'h80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
